mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 183 ++++++++++++++++++
 tb/tb_mdu.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Launches MULT/MULTU/DIV/DIVU from the E stage, keeps busy high for a fixed
// number of cycles (MULT_CYCLES or DIV_CYCLES), then commits the result to
// HI/LO on the edge where busy falls. MTHI/MTLO write HI/LO directly when
// idle. A flush (Req) blocks new work but never cancels work in flight.
//
// Optional build macro:
//   MDU_DIVZERO_HOLD_EN  -- when defined, DIV/DIVU by zero leaves HI/LO
//                           unchanged; otherwise it commits HI=A,
//                           LO=0xFFFFFFFF.
//
// Ports:
//   clk        in   1  clock, all state updates on rising edge
//   reset      in   1  synchronous active-low reset
//   MDUOp      in   3  0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NOP
//   MDU_start  in   1  launch strobe for MULT/MULTU/DIV/DIVU
//   A          in  32  rs operand
//   B          in  32  rt operand
//   Req        in   1  flush of the E-stage instruction
//   busy       out  1  operation in flight
//   HI         out 32  HI register
//   LO         out 32  LO register
// -----------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDUOp,
  input  logic        MDU_start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  // ---------------------------------------------------------------------------
  // Result datapath, fed only from the latched operands.
  // ---------------------------------------------------------------------------
  logic        is_mul;
  logic        mul_signed;
  logic [63:0] a_ext, b_ext, product;

  assign is_mul     = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign mul_signed = (op_q == OP_MULT);

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply
  // equal to the two's-complement signed product.
  assign a_ext   = {{32{a_q[31] & mul_signed}}, a_q};
  assign b_ext   = {{32{b_q[31] & mul_signed}}, b_q};
  assign product = a_ext * b_ext;

  logic        div_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div;
  logic [31:0] uquot, urem;
  logic [31:0] quot, rem;

  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign a_mag      = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag      = b_neg ? (~b_q + 32'd1) : b_q;
  // Divide-by-zero is resolved separately; keep the divider free of X.
  assign b_div      = (b_q == 32'd0) ? 32'd1 : b_mag;
  assign uquot      = a_mag / b_div;
  assign urem       = a_mag % b_div;
  // Magnitude division then sign fix-up: quotient truncates toward zero and
  // the remainder follows the dividend. 0x80000000 / -1 naturally yields
  // 0x80000000 with remainder 0 through this path.
  assign quot       = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
  assign rem        = a_neg ? (~urem + 32'd1) : urem;

  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    if (is_mul) begin
      res_hi = product[63:32];
      res_lo = product[31:0];
    end else if (b_q == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
      res_hi = hi_q;
      res_lo = lo_q;
`else
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
`endif
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: counter, launch, MTHI/MTLO, commit.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != '0) begin
      // In flight: everything else is stalled upstream, Req cannot cancel.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end else if (!Req) begin
      case (MDUOp)
        OP_MULT, OP_MULTU: begin
          if (MDU_start) begin
            cnt_d = CNT_W'(MULT_CYCLES);
            op_d  = MDUOp;
            a_d   = A;
            b_d   = B;
          end
        end
        OP_DIV, OP_DIVU: begin
          if (MDU_start) begin
            cnt_d = CNT_W'(DIV_CYCLES);
            op_d  = MDUOp;
            a_d   = A;
            b_d   = B;
          end
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= OP_NOP;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu. Expected HI/LO and busy duration are
// pushed to a scoreboard queue at launch and popped when busy falls.
// -----------------------------------------------------------------------------
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDUOp;
  logic        MDU_start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MDUOp    (MDUOp),
    .MDU_start(MDU_start),
    .A        (A),
    .B        (B),
    .Req      (Req),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;

  // Reference model: native SystemVerilog arithmetic on 64-bit / int types.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    logic [63:0] r;
    longint      p;
    int          sa, sb;
    r = {hi, lo};
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd1: begin
        p = longint'(sa) * longint'(sb);
        r = 64'(p);
      end
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3, 3'd4: begin
        if (b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
          r = {hi, lo};
`else
          r = {a, 32'hFFFF_FFFF};
`endif
        end else if (op == 3'd4) begin
          r = {a % b, a / b};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {32'd0, 32'h8000_0000};
        end else begin
          r = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MDUOp     = 3'd0;
    MDU_start = 1'b0;
    Req       = 1'b0;
  endtask

  // Drive a launch for one edge and push its expectation.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    e.hi     = ehi;
    e.lo     = elo;
    e.cycles = (op <= 3'd2) ? 5 : 10;
    sb_q.push_back(e);
    MDUOp     = op;
    MDU_start = 1'b1;
    A         = a;
    B         = b;
    tick();
    MDU_start = 1'b0;
    MDUOp     = 3'd0;
    A         = $urandom;
    B         = $urandom;
  endtask

  task automatic launch_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = model(op, a, b, m_hi, m_lo);
    launch(op, a, b, r[63:32], r[31:0]);
  endtask

  // Count remaining busy cycles (pre = cycles already elapsed), then pop the
  // scoreboard and compare duration and committed HI/LO.
  task automatic wait_commit(input string name, input int pre);
    int          n;
    int          held_bad;
    logic [31:0] hold_hi, hold_lo;
    exp_t        e;
    n        = pre;
    held_bad = 0;
    hold_hi  = HI;
    hold_lo  = LO;
    while (busy === 1'b1 && n < 64) begin
      n++;
      if (HI !== hold_hi || LO !== hold_lo) held_bad++;
      tick();
    end
    checks++;
    if (n >= 64) begin
      failures++;
      $display("FAIL %s timeout: busy still %b after %0d cycles, required low", name, busy, n);
    end
    checks++;
    if (held_bad != 0) begin
      failures++;
      $display("FAIL %s hold: HI/LO changed in %0d busy cycles, required 0", name, held_bad);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: queue empty at commit, required 1 entry", name);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (n !== e.cycles) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, n, e.cycles);
    end
    checks++;
    if (HI !== e.hi) begin
      failures++;
      $display("FAIL %s HI: got %h required %h", name, HI, e.hi);
    end
    checks++;
    if (LO !== e.lo) begin
      failures++;
      $display("FAIL %s LO: got %h required %h", name, LO, e.lo);
    end
    $display("txn %s cycles=%0d HI=%h LO=%h", name, n, HI, LO);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    MDUOp     = 3'd1;
    MDU_start = 1'b1;
    Req       = 1'b0;
    A         = 32'hFFFF_FFFF;
    B         = 32'hFFFF_FFFF;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (HI !== 32'd0) begin failures++; $display("FAIL reset_HI: got %h required 0", HI); end
    checks++;
    if (LO !== 32'd0) begin failures++; $display("FAIL reset_LO: got %h required 0", LO); end
    reset = 1'b1;
    idle_inputs();
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_after_busy: got %b required 0", busy); end
    $display("txn reset HI=%h LO=%h busy=%b", HI, LO, busy);
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult();
    launch(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    wait_commit("mult", 0);
    launch(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
    wait_commit("multu", 0);
  endtask

  task automatic test_div();
    launch(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_commit("div_neg", 0);
    launch(3'd4, 32'd7, 32'd2, 32'd1, 32'd3);
    wait_commit("divu", 0);
    launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    wait_commit("div_ovf", 0);
  endtask

  task automatic test_mthi_mtlo();
    MDUOp     = 3'd5;
    MDU_start = 1'b1;
    A         = 32'h1234_5678;
    tick();
    idle_inputs();
    checks++;
    if (HI !== 32'h1234_5678) begin failures++; $display("FAIL mthi_HI: got %h required 12345678", HI); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b required 0", busy); end
    checks++;
    if (LO !== m_lo) begin failures++; $display("FAIL mthi_LO: got %h required %h", LO, m_lo); end
    $display("txn mthi HI=%h LO=%h", HI, LO);
    m_hi = 32'h1234_5678;
    MDUOp = 3'd6;
    A     = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    checks++;
    if (LO !== 32'h0BAD_F00D) begin failures++; $display("FAIL mtlo_LO: got %h required 0badf00d", LO); end
    m_lo = 32'h0BAD_F00D;
    // MTLO while busy must be dropped.
    launch_m(3'd1, 32'd3, 32'd4);
    MDUOp = 3'd6;
    A     = 32'hDEAD_BEEF;
    tick();
    MDUOp = 3'd0;
    checks++;
    if (LO !== m_lo) begin failures++; $display("FAIL mtlo_busy_LO: got %h required %h", LO, m_lo); end
    wait_commit("mult_after_mtlo", 1);
  endtask

  task automatic test_req();
    MDUOp     = 3'd1;
    MDU_start = 1'b1;
    Req       = 1'b1;
    A         = 32'd5;
    B         = 32'd6;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL req_launch_busy: got %b required 0", busy); end
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      failures++;
      $display("FAIL req_launch_hilo: got %h/%h required %h/%h", HI, LO, m_hi, m_lo);
    end
    MDUOp     = 3'd5;
    MDU_start = 1'b0;
    A         = 32'hFFFF_0000;
    tick();
    checks++;
    if (HI !== m_hi) begin failures++; $display("FAIL req_mthi: got %h required %h", HI, m_hi); end
    $display("txn req_blocked busy=%b HI=%h LO=%h", busy, HI, LO);
    idle_inputs();
    launch_m(3'd3, 32'd100, 32'd7);
    tick();
    Req = 1'b1;
    tick();
    Req = 1'b0;
    wait_commit("div_req_pulse", 2);
  endtask

  task automatic test_reset_abort();
    int bad;
    launch_m(3'd3, 32'd1000, 32'd3);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", busy); end
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      failures++;
      $display("FAIL abort_hilo: got %h/%h required 0/0", HI, LO);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL abort_no_commit: got %0d bad cycles required 0", bad); end
    $display("txn reset_abort busy=%b HI=%h LO=%h", busy, HI, LO);
  endtask

  task automatic test_divzero();
    MDUOp = 3'd5;
    A     = 32'hAAAA_0000;
    tick();
    MDUOp = 3'd6;
    A     = 32'h0000_5555;
    tick();
    idle_inputs();
    m_hi = 32'hAAAA_0000;
    m_lo = 32'h0000_5555;
`ifdef MDU_DIVZERO_HOLD_EN
    launch(3'd3, 32'h0000_1234, 32'd0, 32'hAAAA_0000, 32'h0000_5555);
`else
    launch(3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
`endif
    wait_commit("div_zero", 0);
    launch_m(3'd4, 32'h8765_4321, 32'd0);
    wait_commit("divu_zero", 0);
  endtask

  task automatic test_back_to_back();
    launch_m(3'd2, 32'h1234_5678, 32'h9ABC_DEF0);
    // Launch and MTHI attempts held during busy must be ignored.
    MDUOp     = 3'd3;
    MDU_start = 1'b1;
    A         = 32'd100;
    B         = 32'd7;
    wait_commit("multu_b2b", 0);
    launch_m(3'd3, 32'd100, 32'd7);
    MDUOp = 3'd5;
    A     = 32'hCAFE_CAFE;
    wait_commit("div_b2b", 0);
    idle_inputs();
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i == 3) ? 32'hFFFF_FFFF : $urandom;
      if (i == 5) a = 32'h8000_0000;
      launch_m(op, a, b);
      wait_commit("random", 0);
    end
  endtask

  initial begin
    idle_inputs();
    A = 32'd0;
    B = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_req();
    test_reset_abort();
    test_divzero();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
